ov7670_frame_reader: RTL

Single-frame capture and readout controller for the OV7670 + AL422 FIFO camera module. On a start request it gates one complete camera frame into the AL422 (WE/WRST), then resets the read pointer and clocks the frame out of the FIFO (RCLK/RRST/OE). Bytes are delivered as a valid/ready byte stream with start/end-of-frame markers. It drives the cam_* FIFO pins that the board top currently ties off, and runs in the 25 MHz PLL domain.

---
 rtl/ov7670_fifo_pkg.sv | 22 ++
 rtl/ov7670_frame_reader_sync.sv | 29 ++
 rtl/ov7670_frame_reader.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/ov7670_fifo_pkg.sv
// Shared types and constants for the OV7670 + AL422 frame reader.
package ov7670_fifo_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_VS1,
    WRST,
    CAPTURE,
    RRST,
    READ,
    DONE
  } state_t;

  // 640x480 RGB565
  localparam int unsigned OV7670_FRAME_BYTES = 614400;

  // FIFO output drivers are enabled only while the read side is active.
  function automatic logic oe_active(state_t s);
    return (s == RRST) || (s == READ);
  endfunction

endpackage

// File: rtl/ov7670_frame_reader_sync.sv
// Two-flop synchronizer with a registered rising-edge pulse.
// An input edge shows up on rise_o three clocks after it reaches async_i.
module sync_rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic async_i,
  output logic rise_o
);

  logic s1_q, s2_q, s3_q, rise_q;

  // Synchronizer chain and edge pulse register.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      s3_q   <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      s1_q   <= async_i;
      s2_q   <= s1_q;
      s3_q   <= s2_q;
      rise_q <= s2_q & ~s3_q;
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/ov7670_frame_reader.sv
// Single-frame capture into the AL422 FIFO followed by readout as a
// valid/ready byte stream with start/end-of-frame markers.
module ov7670_frame_reader
  import ov7670_fifo_pkg::*;
#(
  parameter int unsigned FRAME_BYTES = OV7670_FRAME_BYTES,
  parameter int unsigned WRST_CYCLES = 4,
  parameter int unsigned RRST_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       cam_vsync,
  input  logic [7:0] cam_data,
  output logic       cam_we,
  output logic       cam_wrst_n,
  output logic       cam_rrst_n,
  output logic       cam_rclk,
  output logic       cam_oe_n,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_sop,
  output logic       out_eop,
  output logic       busy,
  output logic       frame_done
);

  localparam int unsigned CntW = $clog2(FRAME_BYTES + 1);
  localparam int unsigned PhW  = $clog2(WRST_CYCLES + 2 * RRST_CYCLES + 1);

  localparam logic [CntW-1:0] FrameLast = CntW'(FRAME_BYTES);
  localparam logic [CntW-1:0] FirstByte = CntW'(1);
  localparam logic [PhW-1:0]  WrstLast  = PhW'(WRST_CYCLES - 1);
  localparam logic [PhW-1:0]  RrstLast  = PhW'(2 * RRST_CYCLES - 1);

  state_t          state_q, state_d;
  logic [PhW-1:0]  ph_q, ph_d;
  logic [CntW-1:0] bytes_q, bytes_d;
  logic            we_q, we_d;
  logic            wrst_n_q, wrst_n_d;
  logic            rrst_n_q, rrst_n_d;
  logic            rclk_q, rclk_d;
  logic            oe_n_q, oe_n_d;
  logic [7:0]      data_q, data_d;
  logic            valid_q, valid_d;
  logic            sop_q, sop_d;
  logic            eop_q, eop_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            vs_rise;

  sync_rise_detect u_vs_sync (
    .clk     (clk),
    .reset   (reset),
    .async_i (cam_vsync),
    .rise_o  (vs_rise)
  );

  // Next-state logic; every output is derived here and registered below.
  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    bytes_d = bytes_q;
    rclk_d  = 1'b0;
    data_d  = data_q;
    valid_d = valid_q;
    sop_d   = sop_q;
    eop_d   = eop_q;

    unique case (state_q)
      IDLE: begin
        bytes_d = '0;
        valid_d = 1'b0;
        sop_d   = 1'b0;
        eop_d   = 1'b0;
        if (start) state_d = WAIT_VS1;
      end
      WAIT_VS1: begin
        if (vs_rise) begin
          state_d = WRST;
          ph_d    = '0;
        end
      end
      WRST: begin
        if (ph_q == WrstLast) state_d = CAPTURE;
        else                  ph_d    = ph_q + 1'b1;
      end
      CAPTURE: begin
        if (vs_rise) begin
          state_d = RRST;
          ph_d    = '0;
        end
      end
      RRST: begin
        // rclk starts low on entry, so an even phase count leaves it low at exit.
        if (ph_q == RrstLast) begin
          state_d = READ;
          bytes_d = '0;
        end else begin
          ph_d   = ph_q + 1'b1;
          rclk_d = ~rclk_q;
        end
      end
      READ: begin
        if (valid_q && out_ready) begin
          valid_d = 1'b0;
          sop_d   = 1'b0;
          eop_d   = 1'b0;
          if (eop_q) state_d = DONE;
        end
        if (rclk_q) begin
          // Falling half of the read pulse: FIFO data is settled, capture it.
          data_d  = cam_data;
          valid_d = 1'b1;
          sop_d   = (bytes_q == FirstByte);
          eop_d   = (bytes_q == FrameLast);
        end else if ((bytes_q < FrameLast) && (!valid_q || out_ready)) begin
          // Only issue when the output slot is free by the next edge.
          rclk_d  = 1'b1;
          bytes_d = bytes_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    we_d     = (state_d == CAPTURE);
    wrst_n_d = (state_d != WRST);
    rrst_n_d = (state_d != RRST);
    oe_n_d   = ~oe_active(state_d);
    busy_d   = (state_d != IDLE);
    done_d   = (state_d == DONE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      ph_q     <= '0;
      bytes_q  <= '0;
      we_q     <= 1'b0;
      wrst_n_q <= 1'b1;
      rrst_n_q <= 1'b1;
      rclk_q   <= 1'b0;
      oe_n_q   <= 1'b1;
      data_q   <= 8'd0;
      valid_q  <= 1'b0;
      sop_q    <= 1'b0;
      eop_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ph_q     <= ph_d;
      bytes_q  <= bytes_d;
      we_q     <= we_d;
      wrst_n_q <= wrst_n_d;
      rrst_n_q <= rrst_n_d;
      rclk_q   <= rclk_d;
      oe_n_q   <= oe_n_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      sop_q    <= sop_d;
      eop_q    <= eop_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign cam_we     = we_q;
  assign cam_wrst_n = wrst_n_q;
  assign cam_rrst_n = rrst_n_q;
  assign cam_rclk   = rclk_q;
  assign cam_oe_n   = oe_n_q;
  assign out_data   = data_q;
  assign out_valid  = valid_q;
  assign out_sop    = sop_q;
  assign out_eop    = eop_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule
